// File: rtl/support_context_store_pkg.sv
// +----------------------------------------------------------------------------+
// | support_context_store_pkg: decoder stage codes and window-mode type shared |
// | by the context store, its window controller and the bench.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package support_context_store_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING      = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID = 3'd4;

  typedef enum logic [1:0] {
    WIN_FULL = 2'd0,
    WIN_LOW  = 2'd1,
    WIN_HIGH = 2'd2
  } win_mode_t;

  // Context pointer width: max(1, clog2(n)).
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/support_context_store_if.sv
// +----------------------------------------------------------------------------+
// | support_context_store_if: stage/data bus of the context store.             |
// | parity_err exists only with SUPPORT_STORE_PARITY_EN.  Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface support_context_store_if
  import support_context_store_pkg::*;
#(
  parameter int DATA_WIDTH   = 9,
  parameter int NUM_CHANNELS = 4,
  parameter int PTR_WIDTH    = 2
);

  logic [STAGE_WIDTH-1:0]             global_stage;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] input_data;
  logic [NUM_CHANNELS-1:0]            do_not_store;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] output_data;
  logic                               output_valid;
  logic [PTR_WIDTH-1:0]               ctx_ptr;
`ifdef SUPPORT_STORE_PARITY_EN
  logic                               parity_err;
`endif

  modport master (
    output global_stage,
    output input_data,
    output do_not_store,
    input  output_data,
    input  output_valid,
    input  ctx_ptr
`ifdef SUPPORT_STORE_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  global_stage,
    input  input_data,
    input  do_not_store,
    output output_data,
    output output_valid,
    output ctx_ptr
`ifdef SUPPORT_STORE_PARITY_EN
    , output parity_err
`endif
  );

endinterface

`default_nettype wire

// File: rtl/rams_sp_nc.sv
// +----------------------------------------------------------------------------+
// | rams_sp_nc: single-port block RAM, read-first, output held while disabled. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rams_sp_nc #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  wire logic                  clk,
  input  wire logic                  i_en,
  input  wire logic                  i_we,
  input  wire logic [ADDR_WIDTH-1:0] i_addr,
  input  wire logic [DATA_WIDTH-1:0] i_din,
  output logic      [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_din;
      end
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/support_ctx_window.sv
// +----------------------------------------------------------------------------+
// | support_ctx_window: context pointer with FULL/LOW/HIGH wrap windows.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module support_ctx_window
  import support_context_store_pkg::*;
#(
  parameter int NUM_CONTEXTS = 4,
  parameter int PTR_WIDTH    = 2
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic [STAGE_WIDTH-1:0] i_stage,
  input  wire logic                   i_advance,
  output logic      [PTR_WIDTH-1:0]   o_ptr
);

  generate
    if (NUM_CONTEXTS == 1) begin : g_single
      assign o_ptr = '0;
    end else begin : g_multi
      localparam int HALF = NUM_CONTEXTS / 2;
      localparam logic [PTR_WIDTH-1:0] C_LAST      = PTR_WIDTH'(NUM_CONTEXTS - 1);
      localparam logic [PTR_WIDTH-1:0] C_HALF      = PTR_WIDTH'(HALF);
      localparam logic [PTR_WIDTH-1:0] C_HALF_LAST = PTR_WIDTH'(HALF - 1);

      win_mode_t            r_win, w_win_nxt;
      logic                 r_first, w_first_nxt;
      logic [PTR_WIDTH-1:0] r_ptr, w_ptr_nxt, w_min, w_max;
      logic                 w_in_high, w_at_boundary;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ptr   <= '0;
          r_win   <= WIN_LOW;
          r_first <= 1'b0;
        end else begin
          r_ptr   <= w_ptr_nxt;
          r_win   <= w_win_nxt;
          r_first <= w_first_nxt;
        end
      end

      // Pointer advance sees the window already in force this cycle.
      always_comb begin
        w_min = '0;
        w_max = C_LAST;
        case (r_win)
          WIN_LOW:  w_max = C_HALF_LAST;
          WIN_HIGH: w_min = C_HALF;
          default:  ;
        endcase

        w_ptr_nxt = r_ptr;
        if (i_advance) begin
          if (NUM_CONTEXTS == 2)    w_ptr_nxt = ~r_ptr;
          else if (r_ptr == w_max)  w_ptr_nxt = w_min;
          else                      w_ptr_nxt = r_ptr + 1'b1;
        end

        w_in_high     = (r_ptr >= C_HALF);
        w_at_boundary = (r_ptr == '0) || (r_ptr == C_HALF);
        w_win_nxt     = r_win;
        w_first_nxt   = r_first;
        if (w_at_boundary) begin
          case (i_stage)
            STAGE_RESET_ROOTS: begin
              w_first_nxt = 1'b1;
              if (!r_first)             w_win_nxt = WIN_HIGH;
              else if (r_win == WIN_FULL) w_win_nxt = w_in_high ? WIN_LOW : WIN_HIGH;
              else                      w_win_nxt = WIN_FULL;
            end
            STAGE_PEELING:      w_win_nxt = w_in_high ? WIN_HIGH : WIN_LOW;
            STAGE_RESULT_VALID: w_win_nxt = WIN_FULL;
            default: ;
          endcase
        end
      end

      assign o_ptr = r_ptr;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/support_context_store.sv
// +----------------------------------------------------------------------------+
// | support_context_store: per-lane swap store (write new, return old).        |
// | Optional SUPPORT_STORE_PARITY_EN adds even parity and sticky parity_err.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module support_context_store
  import support_context_store_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int NUM_CONTEXTS  = 4,
  parameter int NUM_CHANNELS  = 4
) (
  input wire logic               clk,
  input wire logic               reset,
  support_context_store_if.slave bus
);

  localparam int DATA_WIDTH = ADDRESS_WIDTH + 3;
  localparam int PTR_WIDTH  = ptr_width(NUM_CONTEXTS);
`ifdef SUPPORT_STORE_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  localparam int   RAM_WIDTH  = DATA_WIDTH + PAR_BITS;
  localparam logic C_NO_STORE = (NUM_CONTEXTS == 1);

  logic [STAGE_WIDTH-1:0]             r_stage;
  logic                               r_valid;
  logic [NUM_CHANNELS-1:0]            r_sel;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_byp;
  logic [NUM_CHANNELS*RAM_WIDTH-1:0]  w_rd;
  logic [PTR_WIDTH-1:0]               w_ptr;
  logic                               w_swap, w_advance;

  assign w_swap    = (r_stage == STAGE_WRITE_TO_MEM) && !reset;
  assign w_advance = w_swap && !(&bus.do_not_store);

  // Reset selects the zeroed bypass register so output_data reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= STAGE_IDLE;
      r_valid <= 1'b0;
      r_sel   <= '1;
      r_byp   <= '0;
    end else begin
      r_stage <= bus.global_stage;
      r_valid <= w_swap;
      if (w_swap) begin
        r_sel <= bus.do_not_store | {NUM_CHANNELS{C_NO_STORE}};
        r_byp <= bus.input_data;
      end
    end
  end

  support_ctx_window #(
    .NUM_CONTEXTS (NUM_CONTEXTS),
    .PTR_WIDTH    (PTR_WIDTH)
  ) u_win (
    .clk       (clk),
    .reset     (reset),
    .i_stage   (r_stage),
    .i_advance (w_advance),
    .o_ptr     (w_ptr)
  );

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
      logic [DATA_WIDTH-1:0] w_lane_in;
      assign w_lane_in = bus.input_data[c*DATA_WIDTH +: DATA_WIDTH];

      if (NUM_CONTEXTS > 1) begin : g_ram
        logic [RAM_WIDTH-1:0] w_wr;
`ifdef SUPPORT_STORE_PARITY_EN
        assign w_wr = {^w_lane_in, w_lane_in};
`else
        assign w_wr = w_lane_in;
`endif
        rams_sp_nc #(
          .DATA_WIDTH (RAM_WIDTH),
          .DEPTH      (NUM_CONTEXTS),
          .ADDR_WIDTH (PTR_WIDTH)
        ) u_ram (
          .clk    (clk),
          .i_en   (w_swap),
          .i_we   (w_swap && !bus.do_not_store[c]),
          .i_addr (w_ptr),
          .i_din  (w_wr),
          .o_dout (w_rd[c*RAM_WIDTH +: RAM_WIDTH])
        );
      end else begin : g_bypass
        assign w_rd[c*RAM_WIDTH +: RAM_WIDTH] = '0;
      end

      assign bus.output_data[c*DATA_WIDTH +: DATA_WIDTH] =
        r_sel[c] ? r_byp[c*DATA_WIDTH +: DATA_WIDTH] : w_rd[c*RAM_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef SUPPORT_STORE_PARITY_EN
  logic                    r_par_err;
  logic [NUM_CHANNELS-1:0] w_par_bad;

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_par
      assign w_par_bad[c] = r_valid && !r_sel[c] && (^w_rd[c*RAM_WIDTH +: RAM_WIDTH]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)           r_par_err <= 1'b0;
    else if (|w_par_bad) r_par_err <= 1'b1;
  end

  assign bus.parity_err = r_par_err;
`endif

  assign bus.output_valid = r_valid;
  assign bus.ctx_ptr      = w_ptr;

endmodule

`default_nettype wire

// File: tb/tb_support_context_store.sv
// +----------------------------------------------------------------------------+
// | tb_support_context_store: directed + random bench with a slot-array model. |
// | Parity steps compile only with SUPPORT_STORE_PARITY_EN.  Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_support_context_store;
  import support_context_store_pkg::*;

  localparam int N  = 4;
  localparam int C  = 4;
  localparam int DW = 9;
  localparam int PW = 2;
  localparam int H  = N / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  support_context_store_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(C), .PTR_WIDTH(PW)) bus();

  support_context_store #(
    .ADDRESS_WIDTH (6),
    .NUM_CONTEXTS  (N),
    .NUM_CHANNELS  (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one array of slots per lane plus the pointer/window rules.
  logic [DW-1:0]          m_mem [C][N];
  bit                     m_known [C][N];
  logic [DW-1:0]          m_out [C];
  bit                     m_out_known [C];
  int                     m_ptr;
  win_mode_t              m_win;
  bit                     m_first;
  bit                     m_valid;
  logic [STAGE_WIDTH-1:0] m_stage;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_slot(input int p, input win_mode_t w);
    int lo = 0;
    int hi = N - 1;
    if (w == WIN_LOW)  hi = H - 1;
    if (w == WIN_HIGH) lo = H;
    return (p == hi) ? lo : (p + 1) % N;
  endfunction

  task automatic model_edge();
    int        old_ptr = m_ptr;
    win_mode_t old_win = m_win;
    bit        any_store = 1'b0;
    if (reset) begin
      m_stage = STAGE_IDLE; m_win = WIN_LOW; m_first = 1'b0; m_ptr = 0; m_valid = 1'b0;
      for (int c = 0; c < C; c++) begin m_out[c] = '0; m_out_known[c] = 1'b1; end
      return;
    end
    m_valid = (m_stage == STAGE_WRITE_TO_MEM);
    if (m_valid) begin
      for (int c = 0; c < C; c++) begin
        logic [DW-1:0] lane = bus.input_data[c*DW +: DW];
        if (bus.do_not_store[c]) begin
          m_out[c] = lane; m_out_known[c] = 1'b1;
        end else begin
          m_out[c] = m_mem[c][old_ptr]; m_out_known[c] = m_known[c][old_ptr];
          m_mem[c][old_ptr] = lane; m_known[c][old_ptr] = 1'b1;
          any_store = 1'b1;
        end
      end
      if (any_store) m_ptr = next_slot(old_ptr, old_win);
    end
    if (old_ptr == 0 || old_ptr == H) begin
      if (m_stage == STAGE_RESET_ROOTS) begin
        if (!m_first)               m_win = WIN_HIGH;
        else if (old_win == WIN_FULL) m_win = (old_ptr < H) ? WIN_HIGH : WIN_LOW;
        else                        m_win = WIN_FULL;
        m_first = 1'b1;
      end else if (m_stage == STAGE_PEELING) begin
        m_win = (old_ptr < H) ? WIN_LOW : WIN_HIGH;
      end else if (m_stage == STAGE_RESULT_VALID) begin
        m_win = WIN_FULL;
      end
    end
    m_stage = bus.global_stage;
  endtask

  task automatic check_all();
    check("valid", 32'(bus.output_valid), 32'(m_valid));
    check("ptr", 32'(bus.ctx_ptr), 32'(m_ptr));
    for (int c = 0; c < C; c++)
      if (m_out_known[c])
        check($sformatf("lane%0d", c), 32'(bus.output_data[c*DW +: DW]), 32'(m_out[c]));
  endtask

  task automatic cyc(input logic [STAGE_WIDTH-1:0] stg, input logic [C-1:0] dns,
                     input logic [C*DW-1:0] data);
    bus.global_stage = stg;
    bus.do_not_store = dns;
    bus.input_data   = data;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [C*DW-1:0] rnd_data();
    logic [C*DW-1:0] d;
    for (int c = 0; c < C; c++) d[c*DW +: DW] = DW'($urandom_range(0, 511));
    return d;
  endfunction

  logic [C*DW-1:0] saved [8];
  logic [C*DW-1:0] d;
  int              pulses;
  int              exp_ptr [6];

  initial begin
    for (int c = 0; c < C; c++) for (int s = 0; s < N; s++) m_known[c][s] = 1'b0;
    m_stage = STAGE_IDLE; m_ptr = 0; m_win = WIN_LOW; m_first = 1'b0; m_valid = 1'b0;

    // Reset state
    reset = 1'b1;
    cyc(STAGE_IDLE, '0, '0);
    cyc(STAGE_IDLE, '0, '0);
    check("rst_data", 32'(bus.output_data[DW-1:0]), 32'h0);
    reset = 1'b0;

    // FULL window, four stores then four swaps returning them in order
    cyc(STAGE_RESULT_VALID, '0, '0);
    cyc(STAGE_IDLE, '0, '0);
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    for (int i = 0; i < 8; i++) begin
      saved[i] = rnd_data();
      if (i < 4) saved[i][DW-1:0] = DW'(9'h11 * (i + 1));
      cyc((i < 7) ? STAGE_WRITE_TO_MEM : STAGE_IDLE, '0, saved[i]);
      if (i >= 4) check("swap_lane0", 32'(bus.output_data[DW-1:0]), 32'(9'h11 * (i - 3)));
    end
    check("wrap_ptr0", 32'(bus.ctx_ptr), 32'd0);

    // Mixed bypass/store lanes
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    d = rnd_data();
    d[0*DW +: DW] = 9'h03A;
    d[2*DW +: DW] = 9'h015;
    cyc(STAGE_IDLE, 4'b0101, d);
    check("byp_lane0", 32'(bus.output_data[0*DW +: DW]), 32'h3A);
    check("byp_lane2", 32'(bus.output_data[2*DW +: DW]), 32'h15);
    check("st_lane1", 32'(bus.output_data[1*DW +: DW]), 32'(saved[4][1*DW +: DW]));
    check("st_lane3", 32'(bus.output_data[3*DW +: DW]), 32'(saved[4][3*DW +: DW]));
    check("mix_ptr", 32'(bus.ctx_ptr), 32'd1);

    // All lanes inhibited: pointer holds, valid still pulses
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc((i < 2) ? STAGE_WRITE_TO_MEM : STAGE_IDLE, '1, rnd_data());
      pulses += int'(bus.output_valid);
    end
    check("hold_pulses", 32'(pulses), 32'd3);
    check("hold_ptr", 32'(bus.ctx_ptr), 32'd1);

    // Reset the cycle after a swap, then reset during a swap cycle
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    cyc(STAGE_IDLE, '0, rnd_data());
    reset = 1'b1;
    cyc(STAGE_IDLE, '0, rnd_data());
    check("rst_valid", 32'(bus.output_valid), 32'd0);
    check("rst_lane0", 32'(bus.output_data[DW-1:0]), 32'd0);
    check("rst_ptr", 32'(bus.ctx_ptr), 32'd0);
    reset = 1'b0;
    cyc(STAGE_WRITE_TO_MEM, '0, '0);
    reset = 1'b1;
    cyc(STAGE_IDLE, '0, rnd_data());
    reset = 1'b0;
    cyc(STAGE_IDLE, '0, '0);

    // Window sequence: first RESET_ROOTS -> HIGH, PEELING at 2 -> HIGH, RESULT_VALID -> FULL
    exp_ptr = '{1, 2, 3, 2, 3, 2};
    cyc(STAGE_RESET_ROOTS, '0, '0);
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    for (int i = 0; i < 6; i++) begin
      cyc((i < 5) ? STAGE_WRITE_TO_MEM : STAGE_IDLE, '0, rnd_data());
      check("high_ptr", 32'(bus.ctx_ptr), 32'(exp_ptr[i]));
    end
    cyc(STAGE_PEELING, '0, '0);
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    for (int i = 0; i < 2; i++) begin
      cyc((i < 1) ? STAGE_WRITE_TO_MEM : STAGE_IDLE, '0, rnd_data());
      check("peel_ptr", 32'(bus.ctx_ptr), 32'((i == 0) ? 3 : 2));
    end
    exp_ptr = '{3, 0, 1, 0, 0, 0};
    cyc(STAGE_RESULT_VALID, '0, '0);
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    for (int i = 0; i < 3; i++) begin
      cyc((i < 2) ? STAGE_WRITE_TO_MEM : STAGE_IDLE, '0, rnd_data());
      check("full_ptr", 32'(bus.ctx_ptr), 32'(exp_ptr[i]));
    end

`ifdef SUPPORT_STORE_PARITY_EN
    // Corrupt slot 1 of lane 0 and read it back (pointer is 1 here)
    check("par_clear", 32'(bus.parity_err), 32'd0);
    dut.g_lane[0].g_ram.u_ram.r_mem[1] = dut.g_lane[0].g_ram.u_ram.r_mem[1] ^ 10'd1;
    m_mem[0][1] = m_mem[0][1] ^ 9'd1;
    cyc(STAGE_WRITE_TO_MEM, '1, '0);
    cyc(STAGE_IDLE, '0, rnd_data());
    for (int i = 0; i < 4; i++) begin
      cyc(STAGE_IDLE, '0, '0);
      check("par_sticky", 32'(bus.parity_err), 32'd1);
    end
    reset = 1'b1;
    cyc(STAGE_IDLE, '0, '0);
    reset = 1'b0;
    check("par_reset", 32'(bus.parity_err), 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int              pick = int'($urandom_range(0, 9));
      logic [STAGE_WIDTH-1:0] stg;
      logic [C-1:0]    dns;
      if (pick < 5)       stg = STAGE_WRITE_TO_MEM;
      else if (pick == 5) stg = STAGE_RESET_ROOTS;
      else if (pick == 6) stg = STAGE_PEELING;
      else if (pick == 7) stg = STAGE_RESULT_VALID;
      else                stg = STAGE_IDLE;
      dns   = ($urandom_range(0, 3) == 0) ? '1 : C'($urandom_range(0, 15));
      reset = ($urandom_range(0, 49) == 0);
      cyc(stg, dns, rnd_data());
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
